alu_arbiter: RTL



---
 rtl/alu_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port arbiter/sequencer sharing one my_ALU 16-bit datapath.
// Each port issues operands over a valid/ready request channel. It receives
// the registered result and flags over a valid/ready response channel.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration.
// Without it, the arbiter uses fixed priority and port 0 wins contention.

// my_ALU: combinational 16-bit ALU with zero/negative flags.
// Opcodes: 0 A+B+C, 1 A-B-C, 2 A&B, 3 A|B, 4 A^B, 5 ~A, 6 A<<1, 7 A>>1 (logical).
module my_ALU (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        C,
  input  logic [2:0]  opc,
  output logic [15:0] W,
  output logic        zer,
  output logic        neg
);

  // Opcode decode and result flags
  always_comb begin
    W = '0;
    case (opc)
      3'd0:    W = A + B + {15'd0, C};
      3'd1:    W = A - B - {15'd0, C};
      3'd2:    W = A & B;
      3'd3:    W = A | B;
      3'd4:    W = A ^ B;
      3'd5:    W = ~A;
      3'd6:    W = {A[14:0], 1'b0};
      default: W = {1'b0, A[15:1]};
    endcase
    zer = (W == '0);
    neg = W[15];
  end

endmodule

module alu_arbiter (
  input  logic        clk,
  input  logic        rstN,
  input  logic [1:0]  reqValid,
  output logic [1:0]  reqReady,
  input  logic [15:0] inA0,
  input  logic [15:0] inA1,
  input  logic [15:0] inB0,
  input  logic [15:0] inB1,
  input  logic [1:0]  inC,
  input  logic [2:0]  opc0,
  input  logic [2:0]  opc1,
  output logic [1:0]  rspValid,
  input  logic [1:0]  rspReady,
  output logic [15:0] outW,
  output logic        zer,
  output logic        neg,
  output logic [7:0]  doneCnt0,
  output logic [7:0]  doneCnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic        c_q, c_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] w_q, w_d;
  logic        zer_q, zer_d, neg_q, neg_d;
  logic [1:0]  rspValid_q, rspValid_d;
  logic [7:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic        grant;
  logic        accept;
  logic [15:0] aluW;
  logic        aluZer, aluNeg;
`ifdef ALU_ARB_RR_EN
  logic        lastGrant_q, lastGrant_d;
`endif

  // The ALU only ever sees the operand registers, never the live request ports
  my_ALU u_alu (
    .A   (a_q),
    .B   (b_q),
    .C   (c_q),
    .opc (op_q),
    .W   (aluW),
    .zer (aluZer),
    .neg (aluNeg)
  );

  // Grant selection; grant is only meaningful when some request is valid
  always_comb begin
`ifdef ALU_ARB_RR_EN
    if (&reqValid) grant = ~lastGrant_q;
    else           grant = reqValid[1];
`else
    grant = ~reqValid[0];
`endif
  end

  // Ready is offered only to the granted port, only in IDLE and out of reset
  always_comb begin
    reqReady = '0;
    accept   = (state_q == IDLE) && reqValid[grant];
    if (rstN && state_q == IDLE) reqReady[grant] = reqValid[grant];
  end

  // Next-state and datapath register updates
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    op_d       = op_q;
    w_d        = w_q;
    zer_d      = zer_q;
    neg_d      = neg_q;
    rspValid_d = rspValid_q;
    cnt0_d     = cnt0_q;
    cnt1_d     = cnt1_q;
`ifdef ALU_ARB_RR_EN
    lastGrant_d = lastGrant_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d = grant;
          a_d     = grant ? inA1 : inA0;
          b_d     = grant ? inB1 : inB0;
          c_d     = inC[grant];
          op_d    = grant ? opc1 : opc0;
          state_d = EXEC;
`ifdef ALU_ARB_RR_EN
          lastGrant_d = grant;
`endif
        end
      end
      EXEC: begin
        w_d        = aluW;
        zer_d      = aluZer;
        neg_d      = aluNeg;
        rspValid_d = owner_q ? 2'b10 : 2'b01;
        state_d    = RESP;
      end
      RESP: begin
        if (rspReady[owner_q]) begin
          rspValid_d = '0;
          if (owner_q) cnt1_d = cnt1_q + 8'd1;
          else         cnt0_d = cnt0_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= 1'b0;
      op_q       <= '0;
      w_q        <= '0;
      zer_q      <= 1'b0;
      neg_q      <= 1'b0;
      rspValid_q <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
`ifdef ALU_ARB_RR_EN
      lastGrant_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      op_q       <= op_d;
      w_q        <= w_d;
      zer_q      <= zer_d;
      neg_q      <= neg_d;
      rspValid_q <= rspValid_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
`ifdef ALU_ARB_RR_EN
      lastGrant_q <= lastGrant_d;
`endif
    end
  end

  assign rspValid = rspValid_q;
  assign outW     = w_q;
  assign zer      = zer_q;
  assign neg      = neg_q;
  assign doneCnt0 = cnt0_q;
  assign doneCnt1 = cnt1_q;

endmodule
